sweep_ctrl: RTL
===============

// Module: sweep_ctrl
// PURPOSE
//  Calibration sequencer for the two-axis servo sweep. On START it sweeps the
//  horizontal axis from POS_MIN to POS_MAX, then raises MC so the max counter
//  counts down. It steps the servo back while CNT_RU is high, which returns it
//  to the max-voltage point. It then repeats the same sequence on the vertical
//  axis. Sits directly downstream of the max counter: drives its MC and
//  CNT_CLR, consumes its CNT_RU, and feeds H_POS/V_POS to the PWM stage.
// PARAMETERS
//  POS_W     8    width of servo position words
//  POS_MIN   0    sweep start position (both axes)
//  POS_MAX   180  sweep end position (both axes); POS_MIN < POS_MAX < 2**POS_W
//  POS_INIT  90   position of both axes after RESET
// PORTS
//  CLK       in   1      system clock, all state on rising edge
//  RESET     in   1      asynchronous, active-high reset
//  START     in   1      level; sampled in IDLE/DONE, starts a calibration
//  STEP_TICK in   1      1-cycle strobe, servo step rate (fixed period, >=4 CLK)
//  CNT_RU    in   1      max counter "still running down" flag
//  MC        out  1      max counter direction: 0 = count up, 1 = count down
//  CNT_CLR   out  1      1-cycle clear to max counter (OR'd with comparator rst)
//  H_POS     out  POS_W  horizontal servo position
//  V_POS     out  POS_W  vertical servo position
//  AXIS      out  1      axis being calibrated: 0 = H, 1 = V
//  BUSY      out  1      high in every state except IDLE and DONE
//  CAL_DONE  out  1      high in DONE
// BEHAVIOUR
//  Reset (async): state=IDLE, H_POS=V_POS=POS_INIT, MC=0, CNT_CLR=0, AXIS=0,
//   BUSY=0, CAL_DONE=0, settle flag cleared. All outputs are registered.
//  States: IDLE, H_CLR, H_SWEEP, H_RET, V_CLR, V_SWEEP, V_RET, DONE.
//  IDLE:  START=1 -> H_CLR.
//  H_CLR: one cycle. CNT_CLR=1, H_POS<=POS_MIN, MC=0 -> H_SWEEP.
//  H_SWEEP: MC=0. On STEP_TICK: if H_POS==POS_MAX -> H_RET (MC=1 next cycle,
//   settle flag set), else H_POS<=H_POS+1.
//  H_RET: MC=1. The first cycle in the state is settle: CNT_RU is ignored,
//   because the counter flag lags MC by 1 CLK. After settle:
//   - CNT_RU=0 -> V_CLR, with no further step.
//   - CNT_RU=1 and STEP_TICK -> H_POS<=H_POS-1, saturating at POS_MIN.
//  V_CLR/V_SWEEP/V_RET: identical to the H states, operating on V_POS, with
//   AXIS=1. V_RET exit -> DONE. H_POS holds its value during the V states.
//  DONE: CAL_DONE=1, MC=0, positions held. START=1 -> H_CLR (recalibrate).
//  CNT_CLR is high only in H_CLR and V_CLR: exactly one pulse per axis.
//  Position arithmetic is unsigned POS_W bits.
//   - Increment never passes POS_MAX.
//   - Decrement never goes below POS_MIN; no wrap-around in either direction.
//  Simultaneous events:
//   - STEP_TICK in the same cycle as the CNT_RU=0 exit: exit wins, no step.
//   - STEP_TICK during the settle cycle is ignored.
//   - START while BUSY is ignored.
//  RESET asserted mid-sweep or mid-return: immediate return to reset values.
//   Max counter state is not touched here; the next H_CLR clears it.
// TESTING
//  1 Reset, START=1 for 1 CLK, POS_MIN=0, POS_MAX=4, CNT_RU model = max counter
//    -> CNT_CLR pulses once, H_POS steps 0,1,2,3,4 on ticks, then MC=1.
//  2 Comparator reset injected at H_POS=2 -> on return H_POS steps back to 2,
//    state moves to V_CLR, and V_POS starts from 0.
//  3 CNT_RU held 0 at return entry (max at end) -> H_POS stays at POS_MAX and
//    V_CLR is reached 2 CLK after MC rises.
//  4 CNT_RU stuck 1 during return -> H_POS decrements to 0 and saturates there;
//    MC stays 1; no underflow to 255.
//  5 RESET pulsed during V_SWEEP at V_POS=3 -> next cycle state IDLE,
//    H_POS=V_POS=90, MC=0, BUSY=0.
//  6 Full run to DONE, then START=1 -> CAL_DONE drops, CNT_CLR pulses, and
//    H_POS=POS_MIN; START during BUSY has no effect.

Source files
------------

// File: rtl/sweep_ctrl_if.sv
// Handshake bundle between the sweep sequencer, the max counter and the PWM stage.
// The slave modport is the sequencer's view; master is the environment's view.
interface sweep_ctrl_if #(
   parameter int POS_W = 8
);
   logic             start;
   logic             step_tick;
   logic             cnt_ru;
   logic             mc;
   logic             cnt_clr;
   logic [POS_W-1:0] h_pos;
   logic [POS_W-1:0] v_pos;
   logic             axis;
   logic             busy;
   logic             cal_done;

   modport master (
      output start, step_tick, cnt_ru,
      input  mc, cnt_clr, h_pos, v_pos, axis, busy, cal_done
   );

   modport slave (
      input  start, step_tick, cnt_ru,
      output mc, cnt_clr, h_pos, v_pos, axis, busy, cal_done
   );
endinterface

// File: rtl/sweep_ctrl.sv
// Two-axis servo calibration sequencer: sweep each axis up to POS_MAX, then step
// back while the max counter runs down, landing on the maximum-voltage position.
module sweep_ctrl #(
   parameter int POS_W    = 8,
   parameter int POS_MIN  = 0,
   parameter int POS_MAX  = 180,
   parameter int POS_INIT = 90
) (
   input logic         clk_i,
   input logic         rst_i,
   sweep_ctrl_if.slave bus
);

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_H_CLR   = 3'd1;
   localparam logic [2:0] S_H_SWEEP = 3'd2;
   localparam logic [2:0] S_H_RET   = 3'd3;
   localparam logic [2:0] S_V_CLR   = 3'd4;
   localparam logic [2:0] S_V_SWEEP = 3'd5;
   localparam logic [2:0] S_V_RET   = 3'd6;
   localparam logic [2:0] S_DONE    = 3'd7;

   localparam logic [POS_W-1:0] P_MIN  = POS_W'(POS_MIN);
   localparam logic [POS_W-1:0] P_MAX  = POS_W'(POS_MAX);
   localparam logic [POS_W-1:0] P_INIT = POS_W'(POS_INIT);
   localparam logic [POS_W-1:0] P_ONE  = POS_W'(1);

   logic [2:0]       state_q, state_d;
   logic [POS_W-1:0] h_pos_q, h_pos_d;
   logic [POS_W-1:0] v_pos_q, v_pos_d;
   logic             settle_q, settle_d;
   logic             mc_q, mc_d;
   logic             cnt_clr_q, cnt_clr_d;
   logic             axis_q, axis_d;
   logic             busy_q, busy_d;
   logic             cal_done_q, cal_done_d;

   // Next-state and position update.
   always_comb begin
      state_d  = state_q;
      h_pos_d  = h_pos_q;
      v_pos_d  = v_pos_q;
      settle_d = 1'b0;
      case (state_q)
         S_IDLE, S_DONE: begin
            if (bus.start) state_d = S_H_CLR;
            else           state_d = state_q;
         end
         S_H_CLR: begin
            h_pos_d = P_MIN;
            state_d = S_H_SWEEP;
         end
         S_H_SWEEP: begin
            if (bus.step_tick) begin
               if (h_pos_q >= P_MAX) begin
                  state_d  = S_H_RET;
                  settle_d = 1'b1;
               end else begin
                  h_pos_d = h_pos_q + P_ONE;
               end
            end else begin
               state_d = state_q;
            end
         end
         // The counter flag lags MC by one clock, so the settle cycle ignores it.
         S_H_RET: begin
            if (settle_q)                               state_d = state_q;
            else if (!bus.cnt_ru)                       state_d = S_V_CLR;
            else if (bus.step_tick && h_pos_q > P_MIN) h_pos_d = h_pos_q - P_ONE;
            else                                        h_pos_d = h_pos_q;
         end
         S_V_CLR: begin
            v_pos_d = P_MIN;
            state_d = S_V_SWEEP;
         end
         S_V_SWEEP: begin
            if (bus.step_tick) begin
               if (v_pos_q >= P_MAX) begin
                  state_d  = S_V_RET;
                  settle_d = 1'b1;
               end else begin
                  v_pos_d = v_pos_q + P_ONE;
               end
            end else begin
               state_d = state_q;
            end
         end
         S_V_RET: begin
            if (settle_q)                               state_d = state_q;
            else if (!bus.cnt_ru)                       state_d = S_DONE;
            else if (bus.step_tick && v_pos_q > P_MIN) v_pos_d = v_pos_q - P_ONE;
            else                                        v_pos_d = v_pos_q;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Output decode from the next state so every output leaves a flop.
   always_comb begin
      mc_d       = (state_d == S_H_RET) || (state_d == S_V_RET);
      cnt_clr_d  = (state_d == S_H_CLR) || (state_d == S_V_CLR);
      axis_d     = (state_d == S_V_CLR) || (state_d == S_V_SWEEP) || (state_d == S_V_RET);
      busy_d     = (state_d != S_IDLE) && (state_d != S_DONE);
      cal_done_d = (state_d == S_DONE);
   end

   // State, position and output registers.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q    <= S_IDLE;
         h_pos_q    <= P_INIT;
         v_pos_q    <= P_INIT;
         settle_q   <= 1'b0;
         mc_q       <= 1'b0;
         cnt_clr_q  <= 1'b0;
         axis_q     <= 1'b0;
         busy_q     <= 1'b0;
         cal_done_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         h_pos_q    <= h_pos_d;
         v_pos_q    <= v_pos_d;
         settle_q   <= settle_d;
         mc_q       <= mc_d;
         cnt_clr_q  <= cnt_clr_d;
         axis_q     <= axis_d;
         busy_q     <= busy_d;
         cal_done_q <= cal_done_d;
      end
   end

   assign bus.mc       = mc_q;
   assign bus.cnt_clr  = cnt_clr_q;
   assign bus.h_pos    = h_pos_q;
   assign bus.v_pos    = v_pos_q;
   assign bus.axis     = axis_q;
   assign bus.busy     = busy_q;
   assign bus.cal_done = cal_done_q;

endmodule
